// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: states, instruction classes, opcodes, ALU codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JUMP_REG, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_JR, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILLEGAL
  } iclass_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  // ALU function codes; ADD is zero so the PC adder path sees ADD by default
  localparam logic [5:0] ALU_ADD = 6'h00;
  localparam logic [5:0] ALU_SUB = 6'h01;
  localparam logic [5:0] ALU_AND = 6'h02;
  localparam logic [5:0] ALU_OR  = 6'h03;
  localparam logic [5:0] ALU_SLT = 6'h04;
  localparam logic [5:0] ALU_BEQ = 6'h05;
  localparam logic [5:0] ALU_BNE = 6'h06;

  // pc_src selects
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  // mem_size selects
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_WORD = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct decode into instruction class, ALU code and byte-access flag.
// Latency: purely combinational.
// Backpressure: none.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] cls,
  output logic [5:0] alu_code,
  output logic       is_byte
);

  // Classify the instruction; anything not listed falls through as illegal
  always_comb begin
    cls      = C_ILLEGAL;
    alu_code = ALU_ADD;
    is_byte  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   begin cls = C_RTYPE; alu_code = ALU_ADD; end
          F_SUB:   begin cls = C_RTYPE; alu_code = ALU_SUB; end
          F_AND:   begin cls = C_RTYPE; alu_code = ALU_AND; end
          F_OR:    begin cls = C_RTYPE; alu_code = ALU_OR;  end
          F_SLT:   begin cls = C_RTYPE; alu_code = ALU_SLT; end
          F_JR:    cls = C_JR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_ADDI: begin cls = C_IMM;    alu_code = ALU_ADD; end
      OP_SLTI: begin cls = C_IMM;    alu_code = ALU_SLT; end
      OP_LW:   cls = C_LOAD;
      OP_LB:   begin cls = C_LOAD;   is_byte = 1'b1; end
      OP_SW:   cls = C_STORE;
      OP_SB:   begin cls = C_STORE;  is_byte = 1'b1; end
      OP_BEQ:  begin cls = C_BRANCH; alu_code = ALU_BEQ; end
      OP_BNE:  begin cls = C_BRANCH; alu_code = ALU_BNE; end
      OP_J:    cls = C_JUMP;
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer driving datapath selects/strobes, with retired-instruction counter and illegal-op halt.
// Latency: 3-5 cycles per instruction (plus one per memory stall cycle); outputs Moore except branch pc_src and store pc_write.
// Backpressure: MEM_RD/MEM_WR hold with strobes asserted while mem_ready_in is low.
module multicycle_control
  import mc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode_in,
  input  logic [5:0]  funct_in,
  input  logic        branch_in,
  input  logic        mem_ready_in,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic [5:0]  alu_func,
  output logic        mem_re,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        mem_to_reg,
  output logic        reg_write_en,
  output logic        halted_out,
  output logic [31:0] instret_out
);

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [5:0]  fn_q, fn_d;
  logic [31:0] instret_q, instret_d;

  logic [5:0]  dec_op, dec_fn;
  logic [2:0]  dec_cls_raw;
  iclass_t     cls;
  logic [5:0]  dec_alu;
  logic        dec_byte;

  // DECODE steers on the live ROM output; later states use the captured copy
  assign dec_op = (state_q == S_DECODE) ? opcode_in : op_q;
  assign dec_fn = (state_q == S_DECODE) ? funct_in  : fn_q;

  mc_decode u_decode (
    .opcode   (dec_op),
    .funct    (dec_fn),
    .cls      (dec_cls_raw),
    .alu_code (dec_alu),
    .is_byte  (dec_byte)
  );

  assign cls = iclass_t'(dec_cls_raw);

  // Capture opcode/funct in DECODE and count each PC update as a retirement
  always_comb begin
    op_d      = (state_q == S_DECODE) ? opcode_in : op_q;
    fn_d      = (state_q == S_DECODE) ? funct_in  : fn_q;
    instret_d = instret_q + {31'd0, pc_write};
  end

  // State, latched instruction fields and retirement counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      fn_q      <= 6'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    pc_src       = PC_SEQ;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    alu_src      = 1'b0;
    alu_func     = ALU_ADD;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_size     = MEM_BYTE;
    mem_to_reg   = 1'b0;
    reg_write_en = 1'b0;
    halted_out   = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_write = 1'b1;
        case (cls)
          C_RTYPE:  state_d = S_EXEC_R;
          C_JR:     state_d = S_JUMP_REG;
          C_IMM:    state_d = S_EXEC_I;
          C_LOAD:   state_d = S_ADDR;
          C_STORE:  state_d = S_ADDR;
          C_BRANCH: state_d = S_BRANCH;
          C_JUMP:   state_d = S_JUMP;
          default:  state_d = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        alu_func = dec_alu;
        state_d  = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src  = 1'b1;
        alu_func = dec_alu;
        state_d  = S_WB_ALU;
      end
      S_WB_ALU: begin
        // Keep the ALU inputs steady so the result is still valid at the write edge
        alu_src      = (cls == C_IMM);
        alu_func     = dec_alu;
        reg_dst      = (cls == C_RTYPE);
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDR: begin
        alu_src = 1'b1;
        state_d = (cls == C_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        alu_src  = 1'b1;
        mem_re   = 1'b1;
        mem_size = dec_byte ? MEM_BYTE : MEM_WORD;
        if (mem_ready_in) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        alu_src  = 1'b1;
        mem_we   = 1'b1;
        mem_size = dec_byte ? MEM_BYTE : MEM_WORD;
        if (mem_ready_in) begin
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_WB_MEM: begin
        reg_write_en = 1'b1;
        mem_to_reg   = 1'b1;
        pc_write     = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_func = dec_alu;
        pc_write = 1'b1;
        pc_src   = branch_in ? PC_BRANCH : PC_SEQ;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
        state_d  = S_FETCH;
      end
      S_JUMP_REG: begin
        pc_write = 1'b1;
        pc_src   = PC_REG;
        state_d  = S_FETCH;
      end
      S_HALT: halted_out = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  assign instret_out = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected control vectors queued per instruction, compared as consumed.
// Latency: checks every cycle of each instruction, sampled on the falling edge.
// Backpressure: mem_ready_in held low for planned stall cycles inside memory states.
module tb_multicycle_control;
  import mc_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode_in, funct_in;
  logic        branch_in, mem_ready_in;
  logic        pc_write, ir_write, reg_dst, alu_src, mem_re, mem_we;
  logic        mem_to_reg, reg_write_en, halted_out;
  logic [1:0]  pc_src, mem_size;
  logic [5:0]  alu_func;
  logic [31:0] instret_out;

  multicycle_control dut (
    .clock(clock), .reset(reset), .opcode_in(opcode_in), .funct_in(funct_in),
    .branch_in(branch_in), .mem_ready_in(mem_ready_in), .pc_write(pc_write),
    .pc_src(pc_src), .ir_write(ir_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .alu_func(alu_func), .mem_re(mem_re), .mem_we(mem_we), .mem_size(mem_size),
    .mem_to_reg(mem_to_reg), .reg_write_en(reg_write_en), .halted_out(halted_out),
    .instret_out(instret_out)
  );

  always #5 clock = ~clock;

  wire [18:0] obs = {pc_write, pc_src, ir_write, reg_dst, alu_src, alu_func,
                     mem_re, mem_we, mem_size, mem_to_reg, reg_write_en, halted_out};

  typedef struct {
    string       tag;
    logic [18:0] v;
    logic [31:0] ir;
    logic        rdy;
    logic        br;
  } step_t;

  step_t       sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_cnt = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] ev(input logic pw, input logic [1:0] ps, input logic irw,
                                     input logic rd, input logic a_src, input logic [5:0] af,
                                     input logic re, input logic we, input logic [1:0] sz,
                                     input logic m2r, input logic rw, input logic h);
    return {pw, ps, irw, rd, a_src, af, re, we, sz, m2r, rw, h};
  endfunction

  task automatic push(input string tag, input logic [18:0] v, input logic rdy, input logic br);
    step_t e;
    e.tag = tag; e.v = v; e.ir = model_cnt; e.rdy = rdy; e.br = br;
    if (v[18]) model_cnt = model_cnt + 32'd1;
    sb_q.push_back(e);
  endtask

  // Pop planned cycles, drive their inputs, compare outputs mid-cycle
  task automatic run_steps(input int limit);
    step_t e;
    int n = 0;
    while (sb_q.size() > 0 && n < limit) begin
      e = sb_q.pop_front();
      mem_ready_in = e.rdy;
      branch_in    = e.br;
      @(negedge clock);
      check_val({e.tag, ".ctl"}, {13'd0, obs}, {13'd0, e.v});
      check_val({e.tag, ".instret"}, instret_out, e.ir);
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  // Assert reset mid-cycle: outputs must clear at once, then restart in FETCH
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_val({tag, ".ctl"}, {13'd0, obs}, 32'd0);
    check_val({tag, ".instret"}, instret_out, 32'd0);
    sb_q.delete();
    model_cnt = 32'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Plan the expected cycle sequence of one instruction, then execute up to 'limit' cycles
  task automatic do_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                          input logic br, input int stall, input int limit);
    logic [5:0] code;
    logic [1:0] sz;
    int kind;  // 0 R, 1 jr, 2 imm, 3 load, 4 store, 5 branch, 6 j, 7 illegal
    opcode_in = op;
    funct_in  = fn;
    code = 6'h00;
    sz   = (op == 6'h20 || op == 6'h28) ? 2'd0 : 2'd2;
    case (op)
      6'h00: begin
        kind = 0;
        case (fn)
          6'h20: code = 6'h00;
          6'h22: code = ALU_SUB;
          6'h24: code = ALU_AND;
          6'h25: code = ALU_OR;
          6'h2A: code = ALU_SLT;
          6'h08: kind = 1;
          default: kind = 7;
        endcase
      end
      6'h08: begin kind = 2; code = 6'h00; end
      6'h0A: begin kind = 2; code = ALU_SLT; end
      6'h23, 6'h20: kind = 3;
      6'h2B, 6'h28: kind = 4;
      6'h04: begin kind = 5; code = ALU_BEQ; end
      6'h05: begin kind = 5; code = ALU_BNE; end
      6'h02: kind = 6;
      default: kind = 7;
    endcase
    push({nm, ".fetch"}, 19'd0, 1'b1, 1'b0);
    push({nm, ".decode"}, ev(0, 0, 1, 0, 0, 6'h00, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    case (kind)
      0: begin
        push({nm, ".exec_r"}, ev(0, 0, 0, 0, 0, code, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        push({nm, ".wb_alu"}, ev(1, 0, 0, 1, 0, code, 0, 0, 0, 0, 1, 0), 1'b1, 1'b0);
      end
      1: push({nm, ".jr"}, ev(1, 3, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
      2: begin
        push({nm, ".exec_i"}, ev(0, 0, 0, 0, 1, code, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        push({nm, ".wb_alu"}, ev(1, 0, 0, 0, 1, code, 0, 0, 0, 0, 1, 0), 1'b1, 1'b0);
      end
      3: begin
        push({nm, ".addr"}, ev(0, 0, 0, 0, 1, 6'h00, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        for (int i = 0; i < stall; i++)
          push({nm, ".rd_stall"}, ev(0, 0, 0, 0, 1, 6'h00, 1, 0, sz, 0, 0, 0), 1'b0, 1'b0);
        push({nm, ".rd"}, ev(0, 0, 0, 0, 1, 6'h00, 1, 0, sz, 0, 0, 0), 1'b1, 1'b0);
        push({nm, ".wb_mem"}, ev(1, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 1, 0), 1'b1, 1'b0);
      end
      4: begin
        push({nm, ".addr"}, ev(0, 0, 0, 0, 1, 6'h00, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        for (int i = 0; i < stall; i++)
          push({nm, ".wr_stall"}, ev(0, 0, 0, 0, 1, 6'h00, 0, 1, sz, 0, 0, 0), 1'b0, 1'b0);
        push({nm, ".wr"}, ev(1, 0, 0, 0, 1, 6'h00, 0, 1, sz, 0, 0, 0), 1'b1, 1'b0);
      end
      5: push({nm, ".branch"}, ev(1, br ? 2'd1 : 2'd0, 0, 0, 0, code, 0, 0, 0, 0, 0, 0), 1'b1, br);
      6: push({nm, ".jump"}, ev(1, 2, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
      default:
        for (int i = 0; i < 20; i++)
          push({nm, ".halt"}, ev(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0, 1), 1'b1, 1'b1);
    endcase
    run_steps(limit);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode_in = 6'd0; funct_in = 6'd0; branch_in = 1'b0; mem_ready_in = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    do_reset("reset");

    do_instr("add",  6'h00, 6'h20, 1'b0, 0, 1000);
    do_instr("sub",  6'h00, 6'h22, 1'b0, 0, 1000);
    do_instr("and",  6'h00, 6'h24, 1'b0, 0, 1000);
    do_instr("or",   6'h00, 6'h25, 1'b0, 0, 1000);
    do_instr("slt",  6'h00, 6'h2A, 1'b0, 0, 1000);
    do_instr("addi", 6'h08, 6'h15, 1'b0, 0, 1000);
    do_instr("slti", 6'h0A, 6'h2A, 1'b0, 0, 1000);
    do_instr("lw",   6'h23, 6'h00, 1'b0, 3, 1000);
    do_instr("lb",   6'h20, 6'h00, 1'b0, 0, 1000);
    do_instr("sw",   6'h2B, 6'h00, 1'b0, 2, 1000);
    do_instr("sb",   6'h28, 6'h00, 1'b0, 0, 1000);
    do_instr("beq1", 6'h04, 6'h00, 1'b1, 0, 1000);
    do_instr("beq0", 6'h04, 6'h00, 1'b0, 0, 1000);
    do_instr("bne1", 6'h05, 6'h00, 1'b1, 0, 1000);
    do_instr("bne0", 6'h05, 6'h00, 1'b0, 0, 1000);
    do_instr("j",    6'h02, 6'h00, 1'b0, 0, 1000);
    do_instr("jr",   6'h00, 6'h08, 1'b0, 0, 1000);

    // Store stuck waiting on memory, then reset lands in the middle of the stall
    do_instr("sw_rst", 6'h2B, 6'h00, 1'b0, 10, 5);
    do_reset("rst_stall");
    do_instr("add2", 6'h00, 6'h20, 1'b0, 0, 1000);
    do_instr("lw2",  6'h23, 6'h00, 1'b0, 1, 1000);

    // Illegal opcode halts; counter frozen; reset recovers
    do_instr("ill_op", 6'h3F, 6'h00, 1'b0, 0, 1000);
    do_reset("rst_halt");
    do_instr("ill_fn", 6'h00, 6'h21, 1'b0, 0, 1000);
    do_reset("rst_halt2");
    do_instr("add3", 6'h00, 6'h20, 1'b0, 0, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller that turns the lab processor datapath (pc, inst_rom, register_file, alu, data_memory, mux2 selectors) into a multi-cycle machine. It decodes the fetched opcode/funct and steps a state machine that drives every datapath select and strobe. Data-memory accesses stall on a ready handshake so memory-mapped serial I/O can block. It also keeps a retired-instruction counter and halts on illegal opcodes.

## Interface
- No parameters. Encodings are fixed in the package.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode_in` in 6: inst_rom data_out[31:26], valid in DECODE.
- `funct_in` in 6: inst_rom data_out[5:0], valid in DECODE.
- `branch_in` in 1: alu Branch_out; taken flag while a branch compare code is driven.
- `mem_ready_in` in 1: data_memory access complete; may stay low for many cycles during serial I/O.
- `pc_write` out 1: PC load strobe.
- `pc_src` out 2: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr).
- `ir_write` out 1: instruction register capture.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `alu_src` out 1: 0 = rt data, 1 = sign-extended immediate.
- `alu_func` out 6: ALU function code.
- `mem_re` out 1: data-memory read strobe.
- `mem_we` out 1: data-memory write strobe.
- `mem_size` out 2: 0 = byte, 2 = word.
- `mem_to_reg` out 1: 0 = ALU result, 1 = memory data.
- `reg_write_en` out 1: register-file write strobe.
- `halted_out` out 1: set on an illegal instruction.
- `instret_out` out 32: count of retired instructions.

## Operation
- Supported instructions:
  - R-type (opcode 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - I-type: addi 0x08, slti 0x0A, lw 0x23, lb 0x20, sw 0x2B, sb 0x28, beq 0x04, bne 0x05.
  - J-type: j 0x02.
  - Anything else is illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, JUMP_REG, HALT.
- FETCH -> DECODE unconditionally; inst_rom registers the PC address.
- DECODE: `ir_write`=1. opcode/funct are latched internally. Next state is chosen as follows:
  - R-type other than jr -> EXEC_R.
  - jr -> JUMP_REG.
  - addi/slti -> EXEC_I.
  - loads/stores -> ADDR.
  - beq/bne -> BRANCH.
  - j -> JUMP.
  - Illegal -> HALT.
- EXEC_R: `alu_src`=0, `alu_func`=latched funct; next WB_ALU.
- EXEC_I: `alu_src`=1, `alu_func`=ADD for addi or SLT for slti; next WB_ALU.
- WB_ALU:
  - Operands and `alu_func` are held from the previous state.
  - `reg_write_en`=1, `mem_to_reg`=0, `reg_dst`=1 for R-type and 0 for I-type.
  - `pc_write`=1, `pc_src`=0; next FETCH.
- ADDR: `alu_src`=1, `alu_func`=ADD; next MEM_RD for loads, MEM_WR for stores.
- MEM_RD / MEM_WR:
  - `mem_re` (or `mem_we`) is asserted, with `mem_size` and the address held.
  - The state is held while `mem_ready_in`=0.
  - On ready, MEM_RD goes to WB_MEM.
  - On ready, MEM_WR asserts `pc_write` with `pc_src`=0 in that same cycle, then goes to FETCH.
- WB_MEM: `reg_write_en`=1, `mem_to_reg`=1, `reg_dst`=0, `pc_write`=1, `pc_src`=0; next FETCH.
- BRANCH:
  - `alu_src`=0, `alu_func`=BEQ or BNE code.
  - `pc_write`=1, `pc_src` = `branch_in` ? 1 : 0; next FETCH.
- JUMP: `pc_write`=1, `pc_src`=2. JUMP_REG: `pc_write`=1, `pc_src`=3. Both go to FETCH next.
- HALT is absorbing until reset. All strobes are 0 and `halted_out`=1. The illegal instruction is not counted.
- `instret_out` increments by 1 in the cycle `pc_write`=1 and wraps modulo 2^32.
- Every output not named for a state is 0 in that state.

## Timing
- All outputs are Moore-decoded from the registered state and latched opcode/funct, except two Mealy cases:
  - `pc_src` in BRANCH follows `branch_in`.
  - `pc_write` in MEM_WR follows `mem_ready_in`.
- Cycles per instruction with `mem_ready_in` high:
  - R-type, addi, slti: 4.
  - lw, lb: 5.
  - sw, sb: 4.
  - beq, bne, j, jr: 3.
  - Each cycle of `mem_ready_in` low adds one cycle.
- `mem_re`/`mem_we` stay high, with stable `mem_size`, for every cycle of a stalled access.
- Reset values: state FETCH, every strobe and select 0, `alu_func`=ADD, `halted_out`=0, `instret_out`=0.
- Reset asserted mid-instruction aborts it with no register or PC write. The first FETCH follows the first clock edge after reset deasserts.

## Structure
- Shared package `mc_pkg` holds:
  - The state enum.
  - Opcode and funct constants.
  - ALU codes: ADD=6'h00 (matches the existing PC adder), SUB, AND, OR, SLT, BEQ, BNE.
  - `pc_src` encodings and `mem_size` encodings.
- One sub-module, `mc_decode`: combinational opcode/funct to instruction-class and legality decode. The FSM and counters stay in the top module.

## Test plan
- add (opcode 0, funct 0x20), reset released:
  - `ir_write` in cycle 2.
  - `alu_func`=ADD in EXEC_R.
  - `reg_write_en`=1, `reg_dst`=1, `pc_write`=1 in cycle 4.
  - `instret_out`=1.
- lw (0x23) with `mem_ready_in` low for 3 cycles:
  - `mem_re`=1 and `mem_size`=2 held for 4 cycles.
  - WB_MEM asserts `mem_to_reg`=1 and `reg_write_en`=1.
  - Total 8 cycles.
- beq (0x04):
  - With `branch_in`=1: `pc_src`=1 in cycle 3.
  - Repeated with `branch_in`=0: `pc_src`=0.
  - `reg_write_en` never 1.
- sb (0x28), ready immediately: `mem_we`=1 with `mem_size`=0 in cycle 4, `pc_write`=1 in the same cycle, 4 cycles total.
- Illegal opcode 0x3F: `halted_out`=1 from cycle 3, all strobes 0 for 20 cycles, `instret_out` unchanged; reset clears it.
- Reset asserted during MEM_WR stall: `mem_we` drops immediately, `instret_out`=0, restart in FETCH.
